// File: rtl/uart_tx_queue.sv
// Byte FIFO that feeds uart_top's tx_start/tx_data pair one frame at a time.
// Define UART_TXQ_TIMEOUT_EN to add a watchdog on WAIT_DONE/RELEASE.
module uart_tx_queue #(
    parameter int unsigned DEPTH   = 16,
    parameter logic [19:0] TIMEOUT = 20'd1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    input  logic                   tx_err,
    output logic                   sent,
    output logic                   err_flag,
    output logic [7:0]             err_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StWaitDone, StRelease} state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]     count_q, count_d;
    logic            full_q, empty_q;
    logic            done_q1, done_s, err_q1, err_s;
    logic            tx_start_q, tx_start_d, sent_q, sent_d;
    logic            err_flag_q, err_flag_d, err_event;
    logic [7:0]      tx_data_q, tx_data_d, err_cnt_q, err_cnt_d;
    logic            push, pop, tmo_hit;

    // Queue bookkeeping; a flush in LOAD still honours that cycle's pop.
    assign push = wr_en && !full_q && !flush;
    assign pop  = (state_q == StLoad) && !empty_q;

    always_comb begin
        rp_d    = pop ? rp_q + AW'(1) : rp_q;
        wp_d    = push ? wp_q + AW'(1) : wp_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW + 1)'(1);
        end
        if (flush) begin
            wp_d    = rp_d;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            done_q1 <= 1'b0;
            done_s  <= 1'b0;
            err_q1  <= 1'b0;
            err_s   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            full_q  <= (count_d == (AW + 1)'(DEPTH));
            empty_q <= (count_d == '0);
            done_q1 <= tx_done;
            done_s  <= done_q1;
            err_q1  <= tx_err;
            err_s   <= err_q1;
        end
    end

`ifdef UART_TXQ_TIMEOUT_EN
    logic [19:0] tmo_q, tmo_d;

    assign tmo_hit = ((state_q == StWaitDone) || (state_q == StRelease)) &&
                     (tmo_q == TIMEOUT - 20'd1);

    always_comb begin
        tmo_d = '0;
        if ((state_d == state_q) && ((state_q == StWaitDone) || (state_q == StRelease))) begin
            tmo_d = tmo_q + 20'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo_hit        = 1'b0;
`endif

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            sent_q     <= 1'b0;
            err_flag_q <= 1'b0;
            err_cnt_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            sent_q     <= sent_d;
            err_flag_q <= err_flag_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (!empty_q) state_d = StLoad;
            // A flush racing the IDLE->LOAD decision can leave nothing to pop.
            StLoad:     state_d = empty_q ? StIdle : StWaitDone;
            StWaitDone: begin
                if (done_s)       state_d = StRelease;
                else if (tmo_hit) state_d = StIdle;
            end
            StRelease:  if (!done_s || tmo_hit) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        sent_d     = 1'b0;
        err_event  = 1'b0;
        unique case (state_q)
            StLoad: begin
                if (!empty_q) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = mem[rp_q];
                end
            end
            StWaitDone: begin
                if (done_s) begin
                    tx_start_d = 1'b0;
                    sent_d     = 1'b1;
                    err_event  = err_s;
                end else if (tmo_hit) begin
                    tx_start_d = 1'b0;
                    err_event  = 1'b1;
                end
            end
            StRelease: err_event = done_s && tmo_hit;
            default: ;
        endcase
        err_flag_d = err_flag_q || err_event;
        err_cnt_d  = (err_event && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign sent     = sent_q;
    assign err_flag = err_flag_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: vector table, directed corner sequences and a random run
// scored against a queue model plus a behavioural uart_top responder.
module tb_uart_tx_queue;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic       full, empty, tx_start, sent, err_flag;
    logic [4:0] count;
    logic [7:0] tx_data, err_cnt;
    logic       tx_done = 1'b0;
    logic       tx_err = 1'b0;

    uart_tx_queue #(.DEPTH(DEPTH), .TIMEOUT(20'd50)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
        .full(full), .empty(empty), .count(count), .tx_start(tx_start), .tx_data(tx_data),
        .tx_done(tx_done), .tx_err(tx_err), .sent(sent), .err_flag(err_flag),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Responder standing in for uart_top: tx_done after a delay, held for a length.
    logic resp_on = 1'b0;
    logic resp_rand = 1'b0;
    int   resp_delay = 0;
    int   resp_len = 1;
    int   err_at = -1;
    int   resp_raises = 0;
    int   resp_errs = 0;
    int   r_phase = 0;
    int   r_cnt = 0;
    int   r_len = 1;
    int   r_frames = 0;

    always @(negedge clk) begin
        if (!resp_on) begin
            tx_done = 1'b0; tx_err = 1'b0; r_phase = 0; r_frames = 0;
        end else if (r_phase == 2) begin
            r_cnt--;
            if (r_cnt == 0) begin tx_done = 1'b0; tx_err = 1'b0; r_phase = 3; end
        end else if (r_phase == 3) begin
            if (!tx_start) r_phase = 0;
        end else begin
            if (r_phase == 0 && tx_start) begin
                r_cnt = resp_rand ? int'($urandom_range(0, 3)) : resp_delay;
                r_len = resp_rand ? int'($urandom_range(1, 4)) : resp_len;
                r_phase = 1;
            end
            if (r_phase == 1) begin
                if (r_cnt == 0) begin
                    tx_done = 1'b1;
                    tx_err  = resp_rand ? ($urandom_range(0, 3) == 0) : (r_frames == err_at);
                    if (tx_err) resp_errs++;
                    resp_raises++;
                    r_frames++;
                    r_cnt = r_len;
                    r_phase = 2;
                end else begin
                    r_cnt--;
                end
            end
        end
    end

    // Reference model: plain FIFO of accepted bytes, popped when a frame starts.
    logic [7:0] q[$];
    logic [7:0] out_log[$];
    logic       prev_start = 1'b0;
    int         n_sent = 0;
    int         n_loads = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic w, input logic [7:0] d, input logic f);
        int pre;
        wr_en = w; wr_data = d; flush = f;
        @(posedge clk);
        @(negedge clk);
        if (!rst) begin
            q.delete();
            prev_start = tx_start;
            return;
        end
        pre = q.size();
        if (tx_start && !prev_start) begin
            n_loads++;
            out_log.push_back(tx_data);
            if (pre == 0) begin
                chk("pop_from_empty", 1, 0);
            end else begin
                chk("tx_data_order", int'(tx_data), int'(q[0]));
                void'(q.pop_front());
            end
        end
        if (f) q.delete();
        else if (w && pre < DEPTH) q.push_back(d);
        chk("count", int'(count), q.size());
        chk("empty", int'(empty), int'(q.size() == 0));
        chk("full", int'(full), int'(q.size() == DEPTH));
        if (sent) n_sent++;
        prev_start = tx_start;
    endtask

    task automatic do_reset();
        resp_on = 1'b0;
        rst = 1'b0;
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        out_log.delete();
    endtask

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       f;
        int         cnt;
        logic       st;
        logic [7:0] dat;
    } vec_t;

    vec_t tbl[7];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int k, b_sent, b_loads, b_raise, b_err;

        tbl[0] = '{1'b1, 8'h11, 1'b0, 1, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 2, 1'b0, 8'h00};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 2, 1'b1, 8'h11};  // push coincides with LOAD
        tbl[3] = '{1'b0, 8'h00, 1'b0, 2, 1'b1, 8'h11};
        tbl[4] = '{1'b1, 8'h44, 1'b0, 3, 1'b1, 8'h11};
        tbl[5] = '{1'b1, 8'h55, 1'b1, 0, 1'b1, 8'h11};  // flush drops push, frame continues
        tbl[6] = '{1'b1, 8'h66, 1'b0, 1, 1'b1, 8'h11};

        // Reset hold with writes requested.
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 8'hC3, 1'b0);
            chk("rst_count", int'(count), 0);
            chk("rst_empty", int'(empty), 1);
            chk("rst_tx_start", int'(tx_start), 0);
            chk("rst_err_cnt", int'(err_cnt), 0);
        end
        rst = 1'b1;
        tick(1'b0, 8'h00, 1'b0);
        chk("post_rst_count", int'(count), 0);
        chk("post_rst_empty", int'(empty), 1);
        chk("post_rst_full", int'(full), 0);
        chk("post_rst_tx_start", int'(tx_start), 0);
        chk("post_rst_tx_data", int'(tx_data), 0);
        chk("post_rst_err_flag", int'(err_flag), 0);

        // Vector table with no tx_done response.
        for (int i = 0; i < 7; i++) begin
            tick(tbl[i].w, tbl[i].d, tbl[i].f);
            chk($sformatf("vec%0d_count", i), int'(count), tbl[i].cnt);
            chk($sformatf("vec%0d_tx_start", i), int'(tx_start), int'(tbl[i].st));
            chk($sformatf("vec%0d_tx_data", i), int'(tx_data), int'(tbl[i].dat));
        end

        // Single byte with a 4-cycle tx_done.
        do_reset();
        resp_rand = 1'b0; resp_delay = 0; resp_len = 4; err_at = -1; resp_on = 1'b1;
        b_sent = n_sent;
        tick(1'b1, 8'hA5, 1'b0);
        chk("single_start_n", int'(tx_start), 0);
        tick(1'b0, 8'h00, 1'b0);
        chk("single_start_n1", int'(tx_start), 0);
        tick(1'b0, 8'h00, 1'b0);
        chk("single_start_n2", int'(tx_start), 1);
        chk("single_data", int'(tx_data), 8'hA5);
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            if (!tx_start) begin k = i; break; end
        end
        chk("single_fall_edges", k, 3);
        chk("single_sent_at_fall", int'(sent), 1);
        for (int i = 0; i < 10; i++) tick(1'b0, 8'h00, 1'b0);
        chk("single_sent_pulses", n_sent - b_sent, 1);
        chk("single_count", int'(count), 0);

        // Fill and overflow behind a frame that is held in WAIT_DONE.
        do_reset();
        resp_delay = 0; resp_len = 1;
        tick(1'b1, 8'hFF, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        for (int i = 0; i <= 16; i++) tick(1'b1, 8'(i), 1'b0);
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 16);
        resp_on = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            if (out_log.size() == 17 && !tx_start) break;
        end
        for (int i = 0; i < 8; i++) tick(1'b0, 8'h00, 1'b0);
        chk("fill_frames", out_log.size(), 17);
        if (out_log.size() == 17) begin
            chk("fill_first", int'(out_log[0]), 8'hFF);
            for (int i = 0; i < 16; i++) chk($sformatf("fill_order%0d", i), int'(out_log[i + 1]), i);
        end

        // Error on the second of three frames, then flush with 4 bytes queued.
        do_reset();
        resp_delay = 0; resp_len = 1; err_at = 1;
        b_sent = n_sent;
        tick(1'b1, 8'h31, 1'b0);
        tick(1'b1, 8'h32, 1'b0);
        tick(1'b1, 8'h33, 1'b0);
        resp_on = 1'b1;
        for (int i = 0; i < 200 && (n_sent - b_sent) < 3; i++) tick(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 8'h00, 1'b0);
        chk("err_sent", n_sent - b_sent, 3);
        chk("err_flag", int'(err_flag), 1);
        chk("err_cnt", int'(err_cnt), 1);
        resp_on = 1'b0; err_at = -1;
        tick(1'b1, 8'h70, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 4; i++) tick(1'b1, 8'(8'h70 + i), 1'b0);
        chk("flush_pre_count", int'(count), 4);
        b_sent = n_sent; b_loads = n_loads;
        tick(1'b0, 8'h00, 1'b1);
        chk("flush_count", int'(count), 0);
        chk("flush_inflight", int'(tx_start), 1);
        resp_on = 1'b1;
        for (int i = 0; i < 100 && n_sent == b_sent; i++) tick(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) tick(1'b0, 8'h00, 1'b0);
        chk("flush_frame_done", n_sent - b_sent, 1);
        chk("flush_no_more_loads", n_loads - b_loads, 0);
        chk("flush_err_cnt", int'(err_cnt), 1);

        // Random traffic against the model with a randomised responder.
        do_reset();
        resp_rand = 1'b1;
        b_sent = n_sent; b_loads = n_loads; b_raise = resp_raises; b_err = resp_errs;
        resp_on = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 63) == 0));
        end
        for (int i = 0; i < 600; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            if (q.size() == 0 && !tx_start && r_phase == 0) break;
        end
        for (int i = 0; i < 10; i++) tick(1'b0, 8'h00, 1'b0);
        chk("rand_sent", n_sent - b_sent, resp_raises - b_raise);
        chk("rand_loads", n_loads - b_loads, resp_raises - b_raise);
        chk("rand_err_cnt", int'(err_cnt),
            (resp_errs - b_err) > 255 ? 255 : (resp_errs - b_err));
        chk("rand_err_flag", int'(err_flag), int'((resp_errs - b_err) > 0));
        resp_rand = 1'b0;

`ifdef UART_TXQ_TIMEOUT_EN
        // Watchdog: tx_done never arrives.
        do_reset();
        b_sent = n_sent;
        tick(1'b1, 8'hB1, 1'b0);
        tick(1'b1, 8'hB2, 1'b0);
        for (int i = 0; i < 10 && !tx_start; i++) tick(1'b0, 8'h00, 1'b0);
        chk("tmo_started", int'(tx_start), 1);
        k = 0;
        for (int i = 1; i <= 80; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            if (!tx_start) begin k = i; break; end
        end
        chk("tmo_fall_cycles", k, 50);
        chk("tmo_err_cnt", int'(err_cnt), 1);
        chk("tmo_err_flag", int'(err_flag), 1);
        for (int i = 0; i < 10 && !tx_start; i++) tick(1'b0, 8'h00, 1'b0);
        chk("tmo_next_load", int'(tx_start), 1);
        chk("tmo_next_data", int'(tx_data), 8'hB2);
        chk("tmo_no_sent", n_sent - b_sent, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
